// File: rtl/matrix_display_mode.sv
// matrix_display_mode: reads a slot number over UART, looks it up, and prints the stored matrix
// as decimal ASCII rows. Define DISPLAY_HEADER_EN to prefix the output with an "<m>x<n>\n" line.
`ifndef ELEMENT_WIDTH
`define ELEMENT_WIDTH 8
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 10
`endif

module matrix_display_mode #(
  parameter int ELEMENT_WIDTH = `ELEMENT_WIDTH,
  parameter int ADDR_WIDTH    = `BRAM_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode_active,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  output logic                     clear_rx_buffer,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     query_req,
  output logic [3:0]               query_slot,
  input  logic                     query_valid,
  input  logic                     query_empty,
  input  logic [4:0]               query_m,
  input  logic [4:0]               query_n,
  input  logic [ADDR_WIDTH-1:0]    query_addr,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [ELEMENT_WIDTH-1:0] mem_rd_data,
  input  logic                     timeout_reset,
  output logic [3:0]               sub_state,
  output logic [3:0]               error_code
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, WAIT_SLOT = 4'd1, WAIT_SLOT_CONT = 4'd2, QUERY = 4'd3, SEND_HDR = 4'd4,
    RD_ISSUE = 4'd5, RD_WAIT = 4'd6, SEND_DIG = 4'd7, SEND_SEP = 4'd8, DONE = 4'd9
  } state_t;

  state_t     state;
  logic [7:0] acc;
  logic [7:0] num;
  logic [1:0] dig;
  logic [4:0] m, n, col;
  logic [8:0] idx;
  logic       gap;
  logic       bang;
`ifdef DISPLAY_HEADER_EN
  logic [1:0] hdr_step;
`endif

  logic        tx_ok, rx_ok, is_digit, is_term, bad, col_last, elem_last;
  logic [11:0] acc_mul;
  logic [7:0]  acc_next, dig_val, dig_char;
  logic [8:0]  total;

  function automatic logic [1:0] digits_of(input logic [7:0] v);
    return (v >= 8'd100) ? 2'd2 : ((v >= 8'd10) ? 2'd1 : 2'd0);
  endfunction

  // gap holds off the cycle after a strobe so the transmitter can raise tx_busy
  assign tx_ok     = !tx_busy && !tx_start && !gap;
  assign rx_ok     = rx_done && !clear_rx_buffer;
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_term   = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign bad       = !is_digit && (!is_term || (state == WAIT_SLOT_CONT && acc > 8'd15));
  assign acc_mul   = 12'(acc) * 12'd10 + 12'(rx_data[3:0]);
  assign acc_next  = (acc_mul > 12'd255) ? 8'hFF : acc_mul[7:0];
  assign total     = 9'(m) * 9'(n);
  assign elem_last = (idx == total - 9'd1);
  assign col_last  = (col == n - 5'd1);
  assign dig_char  = dig_val + 8'h30;
  assign sub_state = state;

  always_comb begin
    dig_val = 8'd0;
    case (dig)
      2'd2:    dig_val = num / 8'd100;
      2'd1:    dig_val = (num / 8'd10) % 8'd10;
      default: dig_val = num % 8'd10;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE; acc <= '0; num <= '0; dig <= '0; m <= '0; n <= '0; col <= '0; idx <= '0;
      gap <= 1'b0; bang <= 1'b0; clear_rx_buffer <= 1'b0; tx_data <= '0; tx_start <= 1'b0;
      query_req <= 1'b0; query_slot <= '0; mem_rd_en <= 1'b0; mem_rd_addr <= '0; error_code <= '0;
`ifdef DISPLAY_HEADER_EN
      hdr_step <= '0;
`endif
    end else begin
      tx_start        <= 1'b0;
      clear_rx_buffer <= 1'b0;
      mem_rd_en       <= 1'b0;
      gap             <= tx_start;
      if (!mode_active) begin
        state     <= IDLE;
        query_req <= 1'b0;
        bang      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            acc   <= '0;
            state <= WAIT_SLOT;
          end
          WAIT_SLOT, WAIT_SLOT_CONT: begin
            if (timeout_reset) begin
              state <= IDLE;
            end else if (bang) begin
              // pending '!' must go out before the next byte is accepted
              if (tx_ok) begin
                tx_data  <= 8'h21;
                tx_start <= 1'b1;
                bang     <= 1'b0;
              end
            end else if (rx_ok) begin
              clear_rx_buffer <= 1'b1;
              if (is_digit) begin
                acc   <= acc_next;
                state <= WAIT_SLOT_CONT;
              end else if (bad) begin
                bang       <= 1'b1;
                error_code <= 4'd1;
                acc        <= '0;
                state      <= WAIT_SLOT;
              end else if (state == WAIT_SLOT_CONT) begin
                query_slot <= acc[3:0];
                error_code <= 4'd0;
                query_req  <= 1'b1;
                state      <= QUERY;
              end
            end
          end
          QUERY: begin
            if (query_valid) begin
              query_req <= 1'b0;
              if (query_empty) begin
                bang       <= 1'b1;
                error_code <= 4'd2;
                acc        <= '0;
                state      <= WAIT_SLOT;
              end else begin
                m           <= query_m;
                n           <= query_n;
                idx         <= '0;
                col         <= '0;
                mem_rd_addr <= query_addr;
`ifdef DISPLAY_HEADER_EN
                num      <= 8'(query_m);
                dig      <= digits_of(8'(query_m));
                hdr_step <= 2'd0;
                state    <= SEND_HDR;
`else
                mem_rd_en <= 1'b1;
                state     <= RD_ISSUE;
`endif
              end
            end
          end
`ifdef DISPLAY_HEADER_EN
          SEND_HDR: begin
            if (tx_ok) begin
              tx_start <= 1'b1;
              case (hdr_step)
                2'd0, 2'd2: begin
                  tx_data <= dig_char;
                  if (dig == 2'd0) hdr_step <= hdr_step + 2'd1;
                  else dig <= dig - 2'd1;
                end
                2'd1: begin
                  tx_data  <= 8'h78;
                  num      <= 8'(n);
                  dig      <= digits_of(8'(n));
                  hdr_step <= 2'd2;
                end
                default: begin
                  tx_data   <= 8'h0A;
                  mem_rd_en <= 1'b1;
                  state     <= RD_ISSUE;
                end
              endcase
            end
          end
`endif
          // mem_rd_en is raised on entry, so data is valid while in RD_WAIT
          RD_ISSUE: state <= RD_WAIT;
          RD_WAIT: begin
            num   <= 8'(mem_rd_data);
            dig   <= digits_of(8'(mem_rd_data));
            state <= SEND_DIG;
          end
          SEND_DIG: begin
            if (tx_ok) begin
              tx_data  <= dig_char;
              tx_start <= 1'b1;
              if (dig == 2'd0) state <= SEND_SEP;
              else dig <= dig - 2'd1;
            end
          end
          SEND_SEP: begin
            if (tx_ok) begin
              tx_data  <= col_last ? 8'h0A : 8'h20;
              tx_start <= 1'b1;
              if (elem_last) begin
                state <= DONE;
              end else begin
                idx         <= idx + 9'd1;
                col         <= col_last ? 5'd0 : col + 5'd1;
                mem_rd_addr <= mem_rd_addr + 1'b1;
                mem_rd_en   <= 1'b1;
                state       <= RD_ISSUE;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
